// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Collects results from three producers (0 = add, 1 = mul, 2 = lw) into one
// small FIFO per producer and broadcasts at most one entry per cycle on the
// common data bus. Queues are served round-robin, starting after the last
// port that was granted.
//
// Ports
//   clk, rst_n              single clock, asynchronous active-low reset
//   pN_valid/tag/data       producer N offers {tag,data} this cycle
//   pN_ready                queue N has room (from registered count only)
//   cdb_valid/tag/data      registered broadcast, one-cycle pulse per entry
//   drop_err                sticky: an offer arrived while its queue was full
module cdb_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int UNIT_SIZE = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_valid,
  input  logic [UNIT_SIZE-1:0] p0_tag,
  input  logic [WORD_SIZE-1:0] p0_data,
  output logic                 p0_ready,
  input  logic                 p1_valid,
  input  logic [UNIT_SIZE-1:0] p1_tag,
  input  logic [WORD_SIZE-1:0] p1_data,
  output logic                 p1_ready,
  input  logic                 p2_valid,
  input  logic [UNIT_SIZE-1:0] p2_tag,
  input  logic [WORD_SIZE-1:0] p2_data,
  output logic                 p2_ready,
  output logic                 cdb_valid,
  output logic [UNIT_SIZE-1:0] cdb_tag,
  output logic [WORD_SIZE-1:0] cdb_data,
  output logic                 drop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = UNIT_SIZE + WORD_SIZE;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [2:0]    valid_in;
  logic [2:0]    ready;
  logic [2:0]    nonempty;
  logic [2:0]    grant_oh;
  logic          grant_valid;
  logic [1:0]    grant_idx;
  logic [1:0]    last_grant;
  logic [1:0]    c0, c1, c2;
  logic [EW-1:0] entry_in [3];
  logic [EW-1:0] head     [3];
  logic [EW-1:0] head_sel;

  assign valid_in    = {p2_valid, p1_valid, p0_valid};
  assign entry_in[0] = {p0_tag, p0_data};
  assign entry_in[1] = {p1_tag, p1_data};
  assign entry_in[2] = {p2_tag, p2_data};
  assign p0_ready    = ready[0];
  assign p1_ready    = ready[1];
  assign p2_ready    = ready[2];

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign ready[g]    = (count < CNT_FULL);
    assign nonempty[g] = (count != '0);
    assign head[g]     = mem[rd_ptr];
    assign push        = valid_in[g] & ready[g];
    assign pop         = grant_oh[g];

    // Storage has no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= entry_in[g];
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  function automatic logic [1:0] next_port(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Round-robin search order: the port after last_grant first, last_grant last.
  always_comb begin
    c0          = next_port(last_grant);
    c1          = next_port(c0);
    c2          = next_port(c1);
    grant_valid = 1'b0;
    grant_idx   = c0;
    if (nonempty[c0]) begin
      grant_valid = 1'b1;
      grant_idx   = c0;
    end else if (nonempty[c1]) begin
      grant_valid = 1'b1;
      grant_idx   = c1;
    end else if (nonempty[c2]) begin
      grant_valid = 1'b1;
      grant_idx   = c2;
    end
    grant_oh = grant_valid ? (3'b001 << grant_idx) : 3'b000;
  end

  always_comb begin
    case (grant_idx)
      2'd0:    head_sel = head[0];
      2'd1:    head_sel = head[1];
      default: head_sel = head[2];
    endcase
  end

  // Reset value of last_grant makes port 0 the first to be searched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      drop_err   <= 1'b0;
      last_grant <= 2'd2;
    end else begin
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        {cdb_tag, cdb_data} <= head_sel;
        last_grant          <= grant_idx;
      end
      if (|(valid_in & ~ready)) drop_err <= 1'b1;
    end
  end

endmodule
